// File: rtl/mdu_iter_if.sv
// Start/busy/done handshake bundle for mdu_iter, plus the MDU operation encoding
// used by the execute stage when no shared definitions header supplies it.
`ifndef MDUOP_DEFINES
`define MDUOP_DEFINES
`define MDUOp_WIDTH 3
`define MDUOp_MULH  3'd0
`define MDUOp_MULHU 3'd1
`define MDUOp_MULW  3'd2
`define MDUOp_DIVW  3'd3
`define MDUOp_DIVWU 3'd4
`endif

interface mdu_iter_if #(parameter int WIDTH = 32);
  logic                    start;
  logic [`MDUOp_WIDTH-1:0] op;
  logic [0:WIDTH-1]        a;
  logic [0:WIDTH-1]        b;
  logic                    cancel;
  logic                    busy;
  logic                    done;
  logic [0:WIDTH-1]        c;
  logic [0:3]              d;

  modport master (output start, op, a, b, cancel, input busy, done, c, d);
  modport slave  (input start, op, a, b, cancel, output busy, done, c, d);
endinterface

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply / restoring divide unit with {OV,LT,GT,EQ} flags.
// Optional macro MDU_EARLY_OUT_EN: multiply finishes early once the remaining multiplier bits are zero.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic      clk,
  input  logic      rst,
  mdu_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};

  state_t                  state_r, state_s;
  logic [2*WIDTH-1:0]      acc_r;
  logic [WIDTH-1:0]        opnd_r;
  logic [`MDUOp_WIDTH-1:0] op_r;
  logic                    neg_r;
  logic                    dov_r;
  logic [CNT_W-1:0]        cnt_r;
  logic                    busy_r, done_r;
  logic [WIDTH-1:0]        c_r;
  logic [3:0]              d_r;

  logic                    accept_s, step_s, finish_s, early_s;
  logic                    legal_s, sgn_s, div_s, a_neg_s, b_neg_s, dov_s, op_div_s;
  logic [WIDTH-1:0]        a_in_s, b_in_s, abs_a_s, abs_b_s;
  logic [WIDTH:0]          sum_s, rshift_s;
  logic [WIDTH+1:0]        diff_s;
  logic [2*WIDTH-1:0]      mul_step_s, div_step_s, prod_s;
  logic [WIDTH-1:0]        quo_s, res_s;
  logic                    ov_s;
  logic [3:0]              flags_s;

  // Decode the incoming request: signedness, operand magnitudes, divide overflow.
  always_comb begin
    legal_s = 1'b1;
    sgn_s   = 1'b0;
    div_s   = 1'b0;
    case (bus.op)
      `MDUOp_MULH:  sgn_s = 1'b1;
      `MDUOp_MULHU: sgn_s = 1'b0;
      `MDUOp_MULW:  sgn_s = 1'b1;
      `MDUOp_DIVW:  begin sgn_s = 1'b1; div_s = 1'b1; end
      `MDUOp_DIVWU: div_s = 1'b1;
      default:      legal_s = 1'b0;
    endcase
    a_in_s  = bus.a;
    b_in_s  = bus.b;
    a_neg_s = sgn_s & a_in_s[WIDTH-1];
    b_neg_s = sgn_s & b_in_s[WIDTH-1];
    abs_a_s = a_neg_s ? (~a_in_s + WIDTH'(1)) : a_in_s;
    abs_b_s = b_neg_s ? (~b_in_s + WIDTH'(1)) : b_in_s;
    if (!div_s) begin
      dov_s = 1'b0;
    end else if (b_in_s == ZERO_W) begin
      dov_s = 1'b1;
    end else if (sgn_s && (a_in_s == MOST_NEG) && (b_in_s == ALL_ONES)) begin
      dov_s = 1'b1;
    end else begin
      dov_s = 1'b0;
    end
  end

  // One iteration of each algorithm; acc holds {hi,lo} = {partial/remainder, multiplier/quotient}.
  always_comb begin
    op_div_s   = (op_r == `MDUOp_DIVW) || (op_r == `MDUOp_DIVWU);
    sum_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    mul_step_s = {sum_s, acc_r[WIDTH-1:1]};
    rshift_s   = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    diff_s     = {1'b0, rshift_s} - {2'b00, opnd_r};
    if (diff_s[WIDTH+1]) begin
      div_step_s = {rshift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end else begin
      div_step_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end
  end

`ifdef MDU_EARLY_OUT_EN
  localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);
  logic [WIDTH-1:0]   rem_mask_s;
  logic [CNT_W-1:0]   sh_s;
  logic [2*WIDTH-1:0] early_acc_s;

  // After cnt shifts the unconsumed multiplier bits are the low WIDTH-cnt bits of lo.
  always_comb begin
    rem_mask_s  = ALL_ONES >> cnt_r;
    sh_s        = WIDTH_CNT - cnt_r;
    early_acc_s = acc_r >> sh_s;
    early_s     = !op_div_s && ((acc_r[WIDTH-1:0] & rem_mask_s) == ZERO_W);
  end
`else
  assign early_s = 1'b0;
`endif

  // Sign correction, result select and flag generation for the FIX cycle.
  always_comb begin
    prod_s = neg_r ? (~acc_r + (2*WIDTH)'(1)) : acc_r;
    quo_s  = neg_r ? (~acc_r[WIDTH-1:0] + WIDTH'(1)) : acc_r[WIDTH-1:0];
    case (op_r)
      `MDUOp_MULH, `MDUOp_MULHU: begin
        res_s = prod_s[2*WIDTH-1:WIDTH];
        ov_s  = 1'b0;
      end
      `MDUOp_MULW: begin
        res_s = prod_s[WIDTH-1:0];
        ov_s  = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
      end
      `MDUOp_DIVW, `MDUOp_DIVWU: begin
        res_s = dov_r ? ZERO_W : quo_s;
        ov_s  = dov_r;
      end
      default: begin
        res_s = ZERO_W;
        ov_s  = 1'b0;
      end
    endcase
    flags_s = {ov_s, res_s[WIDTH-1], !res_s[WIDTH-1] && (res_s != ZERO_W), res_s == ZERO_W};
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // FSM next state; cancel beats start in IDLE and aborts CALC/FIX.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.cancel)     state_s = IDLE;
        else if (bus.start) state_s = legal_s ? CALC : FIX;
        else                state_s = IDLE;
      end
      CALC: begin
        if (bus.cancel)                          state_s = IDLE;
        else if (early_s || (cnt_r == LAST_CNT)) state_s = FIX;
        else                                     state_s = CALC;
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM control strobes.
  always_comb begin
    accept_s = 1'b0;
    step_s   = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      IDLE:    accept_s = bus.start & ~bus.cancel;
      CALC:    step_s   = ~bus.cancel;
      FIX:     finish_s = ~bus.cancel;
      default: accept_s = 1'b0;
    endcase
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r  <= {(2*WIDTH){1'b0}};
      opnd_r <= ZERO_W;
      op_r   <= {`MDUOp_WIDTH{1'b0}};
      neg_r  <= 1'b0;
      dov_r  <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      op_r  <= bus.op;
      neg_r <= a_neg_s ^ b_neg_s;
      dov_r <= dov_s;
      cnt_r <= {CNT_W{1'b0}};
      if (!legal_s) begin
        acc_r  <= {(2*WIDTH){1'b0}};
        opnd_r <= ZERO_W;
      end else if (div_s) begin
        acc_r  <= {ZERO_W, abs_a_s};
        opnd_r <= abs_b_s;
      end else begin
        acc_r  <= {ZERO_W, abs_b_s};
        opnd_r <= abs_a_s;
      end
    end else if (step_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
`ifdef MDU_EARLY_OUT_EN
      if (early_s)       acc_r <= early_acc_s;
      else if (op_div_s) acc_r <= div_step_s;
      else               acc_r <= mul_step_s;
`else
      if (op_div_s) acc_r <= div_step_s;
      else          acc_r <= mul_step_s;
`endif
    end
  end

  // Registered outputs; c/d change only on an uncancelled FIX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      c_r    <= ZERO_W;
      d_r    <= 4'b0000;
    end else begin
      busy_r <= (state_s == CALC) || (state_s == FIX);
      done_r <= finish_s;
      if (finish_s) begin
        c_r <= res_s;
        d_r <= flags_s;
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.c    = c_r;
  assign bus.d    = d_r;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: directed corner cases plus random ops against a 64-bit arithmetic model.
`ifndef MDUOP_DEFINES
`define MDUOP_DEFINES
`define MDUOp_WIDTH 3
`define MDUOp_MULH  3'd0
`define MDUOp_MULHU 3'd1
`define MDUOp_MULW  3'd2
`define MDUOp_DIVW  3'd3
`define MDUOp_DIVWU 3'd4
`endif

module tb_mdu_iter;
  localparam int W = 32;

  typedef struct {
    logic [31:0] c;
    logic [3:0]  d;
    int          cyc;
    int          lat;
    bit          exact;
    logic [2:0]  op;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  logic [31:0] last_c = 32'h0;
  logic [3:0]  last_d = 4'h0;

  mdu_iter_if #(.WIDTH(W)) bus ();
  mdu_iter #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural rules.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] c, output logic [3:0] d);
    longint sa, sb, p;
    logic [63:0] up;
    logic ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ov = 1'b0;
    c  = 32'h0;
    case (op)
      `MDUOp_MULH:  begin p = sa * sb; c = p[63:32]; end
      `MDUOp_MULHU: begin up = {32'h0, a} * {32'h0, b}; c = up[63:32]; end
      `MDUOp_MULW: begin
        p  = sa * sb;
        c  = p[31:0];
        ov = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      end
      `MDUOp_DIVW: begin
        if (b == 32'h0 || (a == 32'h80000000 && b == 32'hFFFFFFFF)) ov = 1'b1;
        else begin p = sa / sb; c = p[31:0]; end
      end
      `MDUOp_DIVWU: begin
        if (b == 32'h0) ov = 1'b1;
        else c = a / b;
      end
      default: c = 32'h0;
    endcase
    d = {ov, c[31], (c != 32'h0) && !c[31], c == 32'h0};
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] b, output bit exact);
    exact = 1'b1;
    if (op > `MDUOp_DIVWU) return 2;
`ifdef MDU_EARLY_OUT_EN
    if (op <= `MDUOp_MULW) begin
      exact = 1'b0;
      return (b <= 32'd1) ? 4 : W + 2;
    end
`endif
    return W + 2;
  endfunction

  task automatic issue_exp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ec, input logic [3:0] ed);
    int   n;
    exp_t e;
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("idle_timeout", n >= 200, 1'b0);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    e.c = ec; e.d = ed; e.cyc = cyc; e.op = op;
    e.lat = lat_of(op, b, e.exact);
    sb_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ec;
    logic [3:0]  ed;
    model(op, a, b, ec, ed);
    issue_exp(op, a, b, ec, ed);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || bus.busy === 1'b1) && n < 200) begin @(negedge clk); n++; end
    check("drain_timeout", n >= 200, 1'b0);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return $urandom_range(0, 255);
      5:       return 32'h0 - $urandom_range(1, 255);
      default: return $urandom();
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1'b1, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("c_op%0d", e.op), bus.c, e.c);
        check($sformatf("d_op%0d", e.op), bus.d, e.d);
        check("busy_in_done", bus.busy, 1'b0);
        if (e.exact) check($sformatf("latency_op%0d", e.op), cyc - e.cyc, e.lat);
        else         check($sformatf("latency_max_op%0d", e.op), (cyc - e.cyc) <= e.lat, 1'b1);
        last_c = e.c;
        last_d = e.d;
      end
    end
  end

  initial begin
    logic [2:0] rop;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 3'd0; bus.a = 32'h0; bus.b = 32'h0; bus.cancel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_c", bus.c, 32'h0);
    check("rst_d", bus.d, 4'b0000);
    rst = 1'b0;
    @(negedge clk);

    issue_exp(`MDUOp_MULW,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 4'b0100);
    issue_exp(`MDUOp_MULH,  32'h80000000, 32'h80000000, 32'h40000000, 4'b0010);
    issue_exp(`MDUOp_MULHU, 32'h80000000, 32'h80000000, 32'h40000000, 4'b0010);
    issue_exp(`MDUOp_MULW,  32'h00010000, 32'h00010000, 32'h00000000, 4'b1001);
    issue_exp(`MDUOp_DIVW,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 4'b0100);
    issue_exp(`MDUOp_DIVWU, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 4'b0010);
    issue_exp(`MDUOp_DIVW,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 4'b1001);
    issue_exp(`MDUOp_DIVWU, 32'd5,        32'd0,        32'h00000000, 4'b1001);
    issue_exp(`MDUOp_MULW,  32'd5,        32'd1,        32'h00000005, 4'b0010);
    issue_exp(`MDUOp_MULW,  32'd5,        32'd0,        32'h00000000, 4'b0001);
    issue_exp(3'd7,         32'd9,        32'd9,        32'h00000000, 4'b0001);
    drain();

    // A start pulse while busy must not disturb the operation in flight.
    issue_exp(`MDUOp_DIVWU, 32'd100, 32'd7, 32'd14, 4'b0010);
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.op = `MDUOp_MULW; bus.a = 32'd3; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 4));
      issue(rop, rnd_opnd(), rnd_opnd());
    end
    drain();

    // Cancel mid-divide: busy drops, no done, previous result held.
    issue(`MDUOp_DIVW, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    void'(sb_q.pop_back());
    check("cancel_busy", bus.busy, 1'b0);
    repeat (40) @(negedge clk);
    check("cancel_c_held", bus.c, last_c);
    check("cancel_d_held", bus.d, last_d);

    // Cancel together with start in IDLE: start is not accepted.
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = `MDUOp_MULW; bus.a = 32'd2; bus.b = 32'd2;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    check("cancel_start_busy", bus.busy, 1'b0);
    repeat (40) @(negedge clk);

    // Reset mid-operation clears outputs immediately.
    issue(`MDUOp_MULH, 32'h12345678, 32'h9ABCDEF0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_c", bus.c, 32'h0);
    check("midrst_d", bus.d, 4'b0000);
    sb_q.delete();
    last_c = 32'h0;
    last_d = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue_exp(`MDUOp_MULW, 32'd5, 32'd1, 32'h00000005, 4'b0010);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
